// File: rtl/gf_2to128_multiplier_digit_serial.sv
// Digit-serial GF(2^128) multiplier, GCM bit-reflected convention (bit 127 = x^0).
// Consumes NB_DIGIT bits of X per enabled cycle; optional GHASH chaining with the last result.
module gf_2to128_multiplier_digit_serial #(
  parameter int NB_DATA        = 128,
  parameter int NB_DIGIT       = 8,
  parameter int LOG2_NB_CYCLES = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_start,
  input  logic               i_chain,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_y,
  output logic [NB_DATA-1:0] o_data_z,
  output logic               o_done,
  output logic               o_busy
);

  localparam int NB_CYCLES = (NB_DIGIT > 0) ? NB_DATA / NB_DIGIT : 1;
  localparam bit DIGIT_OK  = (NB_DIGIT == 1)  || (NB_DIGIT == 2)  || (NB_DIGIT == 4)  ||
                             (NB_DIGIT == 8)  || (NB_DIGIT == 16) || (NB_DIGIT == 32) ||
                             (NB_DIGIT == 64) || (NB_DIGIT == 128);
  localparam bit BAD_CONF  = (NB_DATA != 128) || !DIGIT_OK ||
                             ((64'd1 << LOG2_NB_CYCLES) <= 64'(NB_CYCLES));

  localparam logic [NB_DATA-1:0]        R    = {8'he1, {(NB_DATA-8){1'b0}}};
  localparam logic [LOG2_NB_CYCLES-1:0] LAST = LOG2_NB_CYCLES'(NB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t                    state;
  logic [LOG2_NB_CYCLES-1:0] cnt;
  logic [NB_DATA-1:0]        z_acc, v_reg, x_reg;
  logic [NB_DATA-1:0]        z_step, v_step, x_step;

  // One digit = NB_DIGIT unrolled bit steps, X taken MSB (x^0) first.
  always_comb begin
    z_step = z_acc;
    v_step = v_reg;
    x_step = x_reg;
    for (int i = 0; i < NB_DIGIT; i++) begin
      if (x_step[NB_DATA-1]) z_step = z_step ^ v_step;
      v_step = (v_step >> 1) ^ (v_step[0] ? R : '0);
      x_step = x_step << 1;
    end
  end

  // An illegal configuration never leaves reset state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= StIdle;
      cnt      <= '0;
      z_acc    <= '0;
      v_reg    <= '0;
      x_reg    <= '0;
      o_data_z <= '0;
      o_done   <= 1'b0;
    end else if (i_valid && !BAD_CONF) begin
      o_done <= 1'b0;
      if (i_start) begin
        state <= StRun;
        cnt   <= '0;
        z_acc <= '0;
        v_reg <= i_data_y;
        x_reg <= i_chain ? (i_data_x ^ o_data_z) : i_data_x;
      end else begin
        case (state)
          StRun: begin
            z_acc <= z_step;
            v_reg <= v_step;
            x_reg <= x_step;
            if (cnt == LAST) begin
              state    <= StDone;
              o_data_z <= z_step;
              o_done   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StDone:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign o_busy = (state == StRun);

endmodule

// File: tb/tb_gf_2to128_multiplier_digit_serial.sv
// Bench for gf_2to128_multiplier_digit_serial: one instance per legal NB_DIGIT sharing inputs,
// index 3 (NB_DIGIT=8) is the main device; reference is a polynomial multiply-and-reduce model.
module tb_gf_2to128_multiplier_digit_serial;

  localparam int M = 3;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset, valid, start, chain_in;
  logic [127:0] x_in, y_in;
  logic [127:0] z_o    [8];
  logic         done_o [8];
  logic         busy_o [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 8; k++) begin : g_dut
    localparam int DIG = 1 << k;
    localparam bit TB_BAD = ((128 / DIG) * DIG != 128) || (256 <= 128 / DIG);
    initial if (TB_BAD) $fatal(1, "FAIL bad_conf: NB_DIGIT=%0d is not a legal configuration", DIG);
    gf_2to128_multiplier_digit_serial #(
      .NB_DATA(128), .NB_DIGIT(DIG), .LOG2_NB_CYCLES(8)
    ) u_dut (
      .i_clock (clk),
      .i_reset (reset),
      .i_valid (valid),
      .i_start (start),
      .i_chain (chain_in),
      .i_data_x(x_in),
      .i_data_y(y_in),
      .o_data_z(z_o[k]),
      .o_done  (done_o[k]),
      .o_busy  (busy_o[k])
    );
  end

  // Reference: bit-reverse to ordinary polynomials, carry-less multiply, reduce by x^128+x^7+x^2+x+1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p, br;
    logic [127:0] r;
    p  = '0;
    br = '0;
    for (int i = 0; i < 128; i++) br[i] = b[127-i];
    for (int i = 0; i < 128; i++) if (a[127-i]) p = p ^ (br << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i-128]   = ~p[i-128];
        p[i-127]   = ~p[i-127];
        p[i-126]   = ~p[i-126];
        p[i-121]   = ~p[i-121];
      end
    end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a product and waits for o_done; lat counts the start cycle as cycle 1.
  task automatic run_product(input logic [127:0] xv, input logic [127:0] yv, input logic ch,
                             output logic [127:0] zr, output int lat, output int busy_n);
    x_in = xv; y_in = yv; chain_in = ch; start = 1'b1; valid = 1'b1;
    step();
    start = 1'b0; chain_in = 1'b0;
    lat = 1; busy_n = 0;
    while (!done_o[M] && lat < 400) begin
      busy_n += int'(busy_o[M]);
      step();
      lat++;
    end
    zr = z_o[M];
  endtask

  typedef struct {
    string        name;
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] z;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] zr, exp, exp_last, xa, xb, yb, xr, yr, xeff;
    logic         ch, held;
    int           lat, busy_n, en, guard, dones;
    int           lat_k [8];
    logic [127:0] z_k   [8];
    bit           seen  [8];

    vecs[0] = '{"identity", 128'h80000000000000000000000000000000,
                128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210};
    vecs[1] = '{"reduction", 128'h40000000000000000000000000000000,
                128'h00000000000000000000000000000001, 128'he1000000000000000000000000000000};
    vecs[2] = '{"gcm", 128'h0388dace60b6a392f328c2b971b2fe78,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h5e2ec746917062882c85b0685353deb7};
    vecs[3] = '{"x_zero", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    vecs[4] = '{"y_zero", 128'hffffffffffffffffffffffffffffffff, 128'h0, 128'h0};

    reset = 1'b1; valid = 1'b1; start = 1'b0; chain_in = 1'b0; x_in = '0; y_in = '0;
    repeat (3) step();
    check("reset_z", z_o[M], '0);
    check("reset_done", done_o[M], 0);
    check("reset_busy", busy_o[M], 0);
    reset = 1'b0;
    step();

    // Table-driven single products with latency, busy width and pulse width.
    for (int i = 0; i < 5; i++) begin
      run_product(vecs[i].x, vecs[i].y, 1'b0, zr, lat, busy_n);
      check({vecs[i].name, "_z"}, zr, vecs[i].z);
      check({vecs[i].name, "_latency"}, lat, N + 1);
      check({vecs[i].name, "_busy_cycles"}, busy_n, N);
      step();
      check({vecs[i].name, "_done_pulse"}, done_o[M], 0);
      exp_last = vecs[i].z;
    end

    // GCM vector then an immediate chained start from the DONE cycle.
    run_product(vecs[2].x, vecs[2].y, 1'b0, zr, lat, busy_n);
    check("gcm_again_z", zr, vecs[2].z);
    exp = gf_mul(vecs[2].z ^ 128'h0, vecs[2].y);
    run_product('0, vecs[2].y, 1'b1, zr, lat, busy_n);
    check("gcm_chain_z", zr, exp);
    check("gcm_chain_latency", lat, N + 1);
    exp_last = exp;
    step();

    // Reduction vector on every legal digit width.
    x_in = vecs[1].x; y_in = vecs[1].y; start = 1'b1; valid = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin seen[k] = 0; lat_k[k] = 0; z_k[k] = '0; end
    for (int t = 1; t <= 200; t++) begin
      for (int k = 0; k < 8; k++) begin
        if (!seen[k] && done_o[k]) begin seen[k] = 1; lat_k[k] = t; z_k[k] = z_o[k]; end
      end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("reduction_digit%0d_z", 1 << k), z_k[k], vecs[1].z);
      check($sformatf("reduction_digit%0d_latency", 1 << k), lat_k[k], 128 / (1 << k) + 1);
    end
    exp_last = vecs[1].z;

    // Random i_valid stalls during RUN and DONE.
    xa = rand128(); y_in = rand128(); x_in = xa;
    exp = gf_mul(xa, y_in);
    start = 1'b1; valid = 1'b1;
    step();
    start = 1'b0; en = 0; guard = 0;
    while (!done_o[M] && guard < 2000) begin
      valid = ($urandom_range(0, 3) != 0);
      if (valid) en++;
      step();
      guard++;
    end
    check("stall_enabled_cycles", en, N);
    check("stall_z", z_o[M], exp);
    valid = 1'b0;
    repeat (3) step();
    check("stall_done_held", done_o[M], 1);
    check("stall_z_held", z_o[M], exp);
    valid = 1'b1;
    step();
    check("stall_done_cleared", done_o[M], 0);
    exp_last = exp;

    // Abort at step N/2 with new operands.
    xa = rand128(); x_in = xa; y_in = rand128(); start = 1'b1;
    step();
    start = 1'b0; held = 1'b1; dones = 0;
    for (int i = 1; i < N / 2; i++) begin
      if (z_o[M] !== exp_last) held = 1'b0;
      dones += int'(done_o[M]);
      step();
    end
    xb = rand128(); yb = rand128();
    x_in = xb; y_in = yb; start = 1'b1;
    step();
    start = 1'b0; lat = 1;
    while (!done_o[M] && lat < 400) begin
      if (z_o[M] !== exp_last) held = 1'b0;
      step();
      lat++;
    end
    exp = gf_mul(xb, yb);
    check("abort_z_held", held, 1);
    check("abort_no_early_done", dones, 0);
    check("abort_latency", lat, N + 1);
    check("abort_z", z_o[M], exp);
    step();
    check("abort_single_done", done_o[M], 0);

    // Reset mid-run, then a clean product.
    x_in = rand128(); y_in = rand128(); start = 1'b1;
    step();
    start = 1'b0;
    repeat (N / 2) step();
    reset = 1'b1;
    step();
    check("midreset_z", z_o[M], '0);
    check("midreset_done", done_o[M], 0);
    check("midreset_busy", busy_o[M], 0);
    reset = 1'b0;
    exp_last = '0;
    xa = rand128(); yb = rand128();
    exp = gf_mul(xa, yb);
    run_product(xa, yb, 1'b0, zr, lat, busy_n);
    check("post_reset_z", zr, exp);
    exp_last = exp;

    // Back-to-back random products with random chaining, each started in the DONE cycle.
    for (int n = 0; n < 2000; n++) begin
      xr = rand128(); yr = rand128(); ch = 1'($urandom_range(0, 1));
      xeff = ch ? (xr ^ exp_last) : xr;
      exp = gf_mul(xeff, yr);
      run_product(xr, yr, ch, zr, lat, busy_n);
      check($sformatf("random_%0d_z", n), zr, exp);
      exp_last = exp;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
